// File: rtl/pattern_serializer.sv
// Word-to-bit serializer: walks a programmable address range of a small pattern
// memory and shifts each word out one bit per clock, LSB- or MSB-first.
module pattern_serializer #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 16,
  parameter int              AW        = 4,
  parameter int              BW        = 3,
  parameter logic [WIDTH-1:0] INIT_EVEN = 8'hCC,
  parameter logic [WIDTH-1:0] INIT_ODD  = 8'hAA
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic             msb_first,
  input  logic [AW-1:0]    first_word,
  input  logic [AW-1:0]    last_word,
  output logic             out,
  output logic             out_valid,
  output logic [AW-1:0]    word_idx,
  output logic [BW-1:0]    bit_idx,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  function automatic logic [DEPTH-1:0][WIDTH-1:0] mem_init();
    logic [DEPTH-1:0][WIDTH-1:0] r;
    for (int i = 0; i < DEPTH; i++) r[i] = (i % 2 == 1) ? INIT_ODD : INIT_EVEN;
    return r;
  endfunction

  // Pattern store has a power-up image but no reset: clear must not erase it.
  logic [DEPTH-1:0][WIDTH-1:0] mem = mem_init();

  state_t          state;
  logic [AW-1:0]   first_q;
  logic [AW-1:0]   last_q;
  logic            msb_q;
  logic [BW-1:0]   sel;
  logic [WIDTH-1:0] cur_word;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Combinational read so a write to the active word shows up on the next cycle.
  assign cur_word  = mem[word_idx];
  assign sel       = msb_q ? (LAST_BIT - bit_idx) : bit_idx;
  assign out       = out_valid & cur_word[sel];
  assign dbg_state = state;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      word_idx  <= '0;
      bit_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      first_q   <= '0;
      last_q    <= '0;
      msb_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (first_word <= last_word) begin
              first_q   <= first_word;
              last_q    <= last_word;
              msb_q     <= msb_first;
              word_idx  <= first_word;
              bit_idx   <= '0;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort wins over any wrap/loop decision on the same edge.
          if (stop) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (bit_idx == LAST_BIT) begin
            bit_idx <= '0;
            if (word_idx == last_q) begin
              if (loop) begin
                word_idx <= first_q;
              end else begin
                out_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                state     <= DONE;
              end
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end else begin
            bit_idx <= bit_idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: expected bit stream is built from a
// bench-side copy of the pattern memory and checked cycle by cycle.
module tb_pattern_serializer;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic       msb_first = 1'b0;
  logic [3:0] first_word = '0;
  logic [3:0] last_word = '0;
  logic       out;
  logic       out_valid;
  logic [3:0] word_idx;
  logic [2:0] bit_idx;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model_mem [16];
  logic       exp_q [$];
  logic [3:0] exp_w_q [$];

  pattern_serializer dut (
    .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop), .msb_first(msb_first),
    .first_word(first_word), .last_word(last_word), .out(out), .out_valid(out_valid),
    .word_idx(word_idx), .bit_idx(bit_idx), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [3:0] w, input logic m);
    for (int b = 0; b < 8; b++) begin
      exp_q.push_back(m ? model_mem[w][7-b] : model_mem[w][b]);
      exp_w_q.push_back(w);
    end
  endtask

  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    @(negedge clock);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model_mem[a] = d;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  // Leaves the bench at the negedge of the first cycle after the start edge.
  task automatic start_run(input logic [3:0] f, input logic [3:0] l, input logic m);
    @(negedge clock);
    first_word = f; last_word = l; msb_first = m; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic check_stream(input int n, input int drop_loop_at);
    for (int i = 0; i < n; i++) begin
      logic       eb;
      logic [3:0] ew;
      eb = exp_q.pop_front();
      ew = exp_w_q.pop_front();
      check("out_valid", out_valid, 1);
      check("busy", busy, 1);
      check("out", out, eb);
      check("word_idx", word_idx, ew);
      check("bit_idx", bit_idx, i % 8);
      if (i == drop_loop_at) loop = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic check_done;
    check("done_pulse", done, 1);
    check("done_out_valid", out_valid, 0);
    check("done_busy", busy, 0);
    check("done_out", out, 0);
    @(negedge clock);
    check("after_done", done, 0);
    check("after_busy", busy, 0);
    check("after_state", dbg_state, 0);
  endtask

  initial begin
    for (int a = 0; a < 16; a++) model_mem[a] = (a % 2 == 1) ? 8'hAA : 8'hCC;

    // Reset state
    #2;
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_word_idx", word_idx, 0);
    check("rst_bit_idx", bit_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge clock);
    clear = 1'b0;

    // Words 0..1, LSB first then MSB first
    push_word(0, 0); push_word(1, 0);
    start_run(0, 1, 0);
    check_stream(16, -1);
    check_done();

    push_word(0, 1); push_word(1, 1);
    start_run(0, 1, 1);
    check_stream(16, -1);
    check_done();

    // Runtime write, single-word range
    write_word(3, 8'h0F);
    push_word(3, 0);
    start_run(3, 3, 0);
    check_stream(8, -1);
    check_done();

    // Loop over 2..3, dropped after 20 bits: ends after the fourth word
    loop = 1'b1;
    push_word(2, 0); push_word(3, 0); push_word(2, 0); push_word(3, 0);
    start_run(2, 3, 0);
    check_stream(32, 19);
    check_done();

    // Full range with random content, MSB first
    for (int a = 0; a < 16; a++) write_word(4'(a), 8'($urandom_range(0, 255)));
    for (int a = 0; a < 16; a++) push_word(4'(a), 1);
    start_run(0, 15, 1);
    check_stream(128, -1);
    check_done();

    // Rejected start
    start_run(5, 2, 0);
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_out_valid", out_valid, 0);
    check("err_done", done, 0);
    @(negedge clock);
    check("err_cleared", err, 0);
    check("err_state", dbg_state, 0);

    // Stop at bit 3 of word 0
    push_word(0, 0);
    start_run(0, 1, 0);
    check_stream(3, -1);
    check("stop_bit_idx", bit_idx, 3);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check("stop_out_valid", out_valid, 0);
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    check("stop_state", dbg_state, 0);
    @(negedge clock);
    check("stop_no_done", done, 0);
    exp_q.delete(); exp_w_q.delete();

    // Async clear mid-run, then a normal run
    push_word(4, 0);
    start_run(4, 5, 0);
    check_stream(2, -1);
    #2 clear = 1'b1;
    #1;
    check("clr_out_valid", out_valid, 0);
    check("clr_busy", busy, 0);
    check("clr_word_idx", word_idx, 0);
    check("clr_bit_idx", bit_idx, 0);
    check("clr_done", done, 0);
    check("clr_out", out, 0);
    @(negedge clock);
    clear = 1'b0;
    exp_q.delete(); exp_w_q.delete();

    push_word(6, 0); push_word(7, 0);
    start_run(6, 7, 0);
    check_stream(16, -1);
    check_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
Parametrised word-to-bit serializer. A DEPTH x WIDTH pattern memory is read word by word, and each word is shifted out one bit per clock. A bit counter and a word counter drive the read address and bit select. Adds runtime write port, programmable word range, LSB/MSB-first mode, continuous loop, abort, and valid/busy/done/err status. Drives serial test-pattern and stream outputs in the datapath.

Parameters:
WIDTH, 8, bits per memory word (>=2)
DEPTH, 16, number of memory words
AW, 4, address width; DEPTH == 2**AW
BW, 3, bit-index width; WIDTH <= 2**BW
INIT_EVEN, 8'hCC, time-0 content of even addresses (WIDTH bits)
INIT_ODD, 8'hAA, time-0 content of odd addresses (WIDTH bits)

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous active-high reset
wr_en  input  1  memory write strobe
wr_addr  input  AW  write address
wr_data  input  WIDTH  write data
start  input  1  begin a run (sampled in IDLE only)
stop  input  1  abort the current run
loop  input  1  restart at first_word after last_word (sampled live)
msb_first  input  1  bit order, latched at start
first_word  input  AW  first address of range, latched at start
last_word  input  AW  last address of range, latched at start
out  output  1  serial data bit
out_valid  output  1  out carries a valid bit this cycle
word_idx  output  AW  address of the word being shifted
bit_idx  output  BW  bit counter within the word (0..WIDTH-1)
busy  output  1  state is RUN
done  output  1  one-cycle pulse on normal completion
err  output  1  one-cycle pulse on rejected start

Behaviour:
- One clock; reset is asynchronous and active-high: clock, clear.
- clear (async): state=IDLE; out=0, out_valid=0, word_idx=0, bit_idx=0, busy=0, done=0, err=0. Latched range and mode are cleared to 0. Memory is not affected by clear.
- Memory: at time 0, even addresses hold INIT_EVEN and odd addresses hold INIT_ODD. Writes are synchronous on wr_en, allowed in any state. Reads are combinational from the array.
- If a write hits the word being shifted, the new data is visible from the cycle after the write edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and first_word<=last_word: latch first/last/msb_first; word_idx=first_word, bit_idx=0; go to RUN.
  - start=1 and first_word>last_word: err=1 for one cycle; stay in IDLE.
- RUN:
  - out_valid=1, busy=1.
  - out = mem[word_idx][bit_idx] when msb_first=0, else mem[word_idx][WIDTH-1-bit_idx].
  - Each cycle bit_idx increments.
  - At bit_idx==WIDTH-1: bit_idx wraps to 0 and word_idx increments.
  - At word_idx==last and bit_idx==WIDTH-1: if loop=1, word_idx=first and stay in RUN; else go to DONE.
- DONE: done=1, out_valid=0, busy=0 for one cycle; then IDLE.
- stop=1 in RUN: go to IDLE at the next edge with no done pulse. stop has priority over wrap/loop.
- start while RUN or DONE is ignored, with no err.
- out=0 whenever out_valid=0.
- Latency: with start sampled at edge k, the first valid bit appears in the cycle after edge k. out_valid stays high for exactly (last-first+1)*WIDTH consecutive cycles, then done pulses.
- first==last is legal (single word). With first=0 and last=DEPTH-1, word_idx runs through all addresses with no wrap beyond last.
- clear mid-RUN aborts immediately (async), with no done.

Test Plan:
- Default init; first=0, last=1, msb_first=0, pulse start -> out = 0,0,1,1,0,0,1,1, 0,1,0,1,0,1,0,1 over 16 valid cycles; done pulses on the 17th cycle; busy=0 after.
- Same range, msb_first=1 -> out = 1,1,0,0,1,1,0,0, 1,0,1,0,1,0,1,0; word_idx 0 then 1.
- Write addr 3 = 8'h0F, then run first=3, last=3, LSB-first -> 1,1,1,1,0,0,0,0; done after 8 valid bits.
- first=2, last=3, loop=1 for 20 cycles then loop=0 -> word_idx sequence 2,3,2,3,...; run ends cleanly after the last word at which loop=0 was sampled; single done pulse.
- start with first=5, last=2 -> err pulse of 1 cycle; busy, out_valid, done remain 0.
- stop at bit_idx=3 of word 0 -> IDLE next edge with no done. A separate run with clear asserted mid-RUN -> all outputs 0 immediately; the next start behaves normally.
